// File: rtl/uart_rx_frame_parser_if.sv
// FIFO-side and stream-side signals of the RX frame parser.
// The parser takes the master view and the FIFO/consumer side takes the slave view.
interface uart_rx_frame_parser_if;
  logic       rf_empty;
  logic [7:0] rf_out;
  logic       fifo_rd;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_ready;
  logic       pkt_last;
  logic       pkt_done;
  logic       pkt_err;
  logic [1:0] err_code;

  modport master (
    input  rf_empty, rf_out, pkt_ready,
    output fifo_rd, pkt_data, pkt_valid, pkt_last, pkt_done, pkt_err, err_code
  );

  modport slave (
    output rf_empty, rf_out, pkt_ready,
    input  fifo_rd, pkt_data, pkt_valid, pkt_last, pkt_done, pkt_err, err_code
  );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// Frame parser behind the UART RX FIFO: SYNC, LEN, payload, CSUM.
// Payload bytes stream out on valid/ready; the checksum verdict pulses afterwards.
module uart_rx_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned MAX_LEN     = 32,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input logic                    clk_main,
  input logic                    rst_main,
  uart_rx_frame_parser_if.master bus
);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 1);
  localparam logic [1:0]  ERR_LEN   = 2'b01;
  localparam logic [1:0]  ERR_CSUM  = 2'b10;
  localparam logic [1:0]  ERR_TMO   = 2'b11;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        rd_pending_r;
  logic        rd_s;
  logic [7:0]  sum_r, sum_s;
  logic [7:0]  remaining_r, remaining_s;
  logic [15:0] tmo_r, tmo_s;
  logic [7:0]  pkt_data_r, pkt_data_s;
  logic        pkt_valid_r, pkt_valid_s;
  logic        pkt_last_r, pkt_last_s;
  logic        pkt_done_r, pkt_done_s;
  logic        pkt_err_r, pkt_err_s;
  logic [1:0]  err_code_r, err_code_s;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] val);
    return acc + val;
  endfunction

  // Read strobe: one read in flight at most, and never over a held payload beat
  always_comb begin
    rd_s = 1'b0;
    if (rst_main || bus.rf_empty || rd_pending_r) begin
      rd_s = 1'b0;
    end else if ((state_r == ST_PAYLOAD) && pkt_valid_r) begin
      rd_s = 1'b0;
    end else begin
      rd_s = 1'b1;
    end
  end

  // Frame FSM, checksum, timeout and output-stream next values
  always_comb begin
    state_s     = state_r;
    sum_s       = sum_r;
    remaining_s = remaining_r;
    tmo_s       = tmo_r;
    pkt_data_s  = pkt_data_r;
    pkt_valid_s = pkt_valid_r;
    pkt_last_s  = pkt_last_r;
    pkt_done_s  = 1'b0;
    pkt_err_s   = 1'b0;
    err_code_s  = err_code_r;

    if (pkt_valid_r && bus.pkt_ready) begin
      pkt_valid_s = 1'b0;
      pkt_last_s  = 1'b0;
      pkt_data_s  = 8'h00;
    end else begin
      pkt_valid_s = pkt_valid_r;
    end

    if (rd_pending_r) begin
      // A capture always wins over a timeout on the same cycle
      tmo_s = 16'd0;
      case (state_r)
        ST_HUNT: begin
          if (bus.rf_out == SYNC_BYTE) begin
            state_s = ST_LEN;
          end else begin
            state_s = ST_HUNT;
          end
        end
        ST_LEN: begin
          if ((bus.rf_out != 8'd0) && (bus.rf_out <= MAX_LEN_B)) begin
            sum_s       = bus.rf_out;
            remaining_s = bus.rf_out;
            state_s     = ST_PAYLOAD;
          end else begin
            pkt_err_s  = 1'b1;
            err_code_s = ERR_LEN;
            state_s    = ST_HUNT;
          end
        end
        ST_PAYLOAD: begin
          pkt_data_s  = bus.rf_out;
          pkt_valid_s = 1'b1;
          pkt_last_s  = (remaining_r == 8'd1);
          sum_s       = csum_add(sum_r, bus.rf_out);
          remaining_s = remaining_r - 8'd1;
          if (remaining_r == 8'd1) begin
            state_s = ST_CSUM;
          end else begin
            state_s = ST_PAYLOAD;
          end
        end
        ST_CSUM: begin
          if (bus.rf_out == sum_r) begin
            pkt_done_s = 1'b1;
          end else begin
            pkt_err_s  = 1'b1;
            err_code_s = ERR_CSUM;
          end
          state_s = ST_HUNT;
        end
        default: begin
          state_s = ST_HUNT;
        end
      endcase
    end else if (state_r == ST_HUNT) begin
      tmo_s = 16'd0;
    end else if (tmo_r == TMO_LAST) begin
      pkt_err_s  = 1'b1;
      err_code_s = ERR_TMO;
      state_s    = ST_HUNT;
      tmo_s      = 16'd0;
    end else if (bus.rf_empty && !(pkt_valid_r && !bus.pkt_ready)) begin
      // Only a starved FIFO counts; back-pressure stalls are not idle time
      tmo_s = tmo_r + 16'd1;
    end else begin
      tmo_s = tmo_r;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_main) begin
    if (rst_main) begin
      state_r      <= ST_HUNT;
      rd_pending_r <= 1'b0;
      sum_r        <= 8'h00;
      remaining_r  <= 8'h00;
      tmo_r        <= 16'd0;
      pkt_data_r   <= 8'h00;
      pkt_valid_r  <= 1'b0;
      pkt_last_r   <= 1'b0;
      pkt_done_r   <= 1'b0;
      pkt_err_r    <= 1'b0;
      err_code_r   <= 2'b00;
    end else begin
      state_r      <= state_s;
      rd_pending_r <= rd_s;
      sum_r        <= sum_s;
      remaining_r  <= remaining_s;
      tmo_r        <= tmo_s;
      pkt_data_r   <= pkt_data_s;
      pkt_valid_r  <= pkt_valid_s;
      pkt_last_r   <= pkt_last_s;
      pkt_done_r   <= pkt_done_s;
      pkt_err_r    <= pkt_err_s;
      err_code_r   <= err_code_s;
    end
  end

  assign bus.fifo_rd   = rd_s;
  assign bus.pkt_data  = pkt_data_r;
  assign bus.pkt_valid = pkt_valid_r;
  assign bus.pkt_last  = pkt_last_r;
  assign bus.pkt_done  = pkt_done_r;
  assign bus.pkt_err   = pkt_err_r;
  assign bus.err_code  = err_code_r;
endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Self-checking bench: a non-FWFT FIFO feeds byte streams; a frame-level reference
// model predicts payload beats and done/error verdicts, checked on the consumer side.
module tb_uart_rx_frame_parser;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         MAXL = 32;
  localparam int         TMO  = 200;

  typedef logic [7:0] bq_t[$];

  logic clk_main = 1'b0;
  logic rst_main = 1'b1;

  uart_rx_frame_parser_if bus();

  uart_rx_frame_parser #(
    .SYNC_BYTE  (SYNC),
    .MAX_LEN    (MAXL),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_main(clk_main),
    .rst_main(rst_main),
    .bus     (bus)
  );

  always #5 clk_main = ~clk_main;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] fifo_q[$];
  bq_t        stim;
  logic [8:0] exp_beats[$];
  int         exp_st[$];   // 0 = done, 1..3 = error code
  logic [1:0] last_err = 2'b00;
  logic       rd_seen = 1'b0;
  logic       hold_ready = 1'b0;
  logic       rnd_ready = 1'b0;
  logic       gaps_en = 1'b0;
  logic       mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: walk the byte list and predict beats and verdicts.
  // A stream that ends inside a frame is predicted to time out.
  task automatic model_stream(input bq_t b);
    int i;
    int n;
    int len;
    logic [7:0] sum;
    i = 0;
    n = b.size();
    while (i < n) begin
      if (b[i] != SYNC) begin
        i++;
      end else begin
        i++;
        if (i >= n) begin exp_st.push_back(3); return; end
        len = int'(b[i]);
        i++;
        if (len == 0 || len > MAXL) begin
          exp_st.push_back(1);
        end else begin
          sum = 8'(len);
          for (int k = 0; k < len; k++) begin
            if (i >= n) begin exp_st.push_back(3); return; end
            exp_beats.push_back({(k == len - 1), b[i]});
            sum = sum + b[i];
            i++;
          end
          if (i >= n) begin exp_st.push_back(3); return; end
          exp_st.push_back((b[i] == sum) ? 0 : 2);
          i++;
        end
      end
    end
  endtask

  task automatic send();
    model_stream(stim);
    foreach (stim[j]) fifo_q.push_back(stim[j]);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (fifo_q.size() != 0 && t < 5000) begin
      @(posedge clk_main);
      t++;
    end
    chk("drain_bound", {31'd0, fifo_q.size() == 0}, 32'd1);
    repeat (2 * TMO + 50) @(posedge clk_main);
    chk("beats_left", exp_beats.size(), 32'd0);
    chk("status_left", exp_st.size(), 32'd0);
  endtask

  task automatic add_frame(input int kind);
    logic [7:0] len;
    logic [7:0] sum;
    logic [7:0] d;
    stim.push_back(SYNC);
    if (kind == 2) begin
      len = ($urandom % 2 == 0) ? 8'd0 : 8'(33 + $urandom % 223);
      stim.push_back(len);
    end else begin
      len = 8'(1 + $urandom % MAXL);
      stim.push_back(len);
      sum = len;
      for (int k = 0; k < int'(len); k++) begin
        d = 8'($urandom);
        stim.push_back(d);
        sum = sum + d;
      end
      if (kind == 1) sum = sum + 8'(1 + $urandom % 255);
      stim.push_back(sum);
    end
  endtask

  // FIFO model, consumer and monitor: sample at negedge, drive just after posedge
  initial begin
    bus.rf_empty  = 1'b1;
    bus.rf_out    = 8'h00;
    bus.pkt_ready = 1'b0;
    forever begin
      @(negedge clk_main);
      rd_seen = bus.fifo_rd;
      if (mon_en) begin
        if (bus.pkt_valid && bus.pkt_ready) begin
          if (exp_beats.size() == 0) chk("beat_extra", {23'd0, bus.pkt_last, bus.pkt_data}, 32'hFFFF_FFFF);
          else chk("beat", {23'd0, bus.pkt_last, bus.pkt_data}, {23'd0, exp_beats.pop_front()});
        end
        if (bus.pkt_done || bus.pkt_err) begin
          int e;
          chk("pulse_excl", {31'd0, bus.pkt_done && bus.pkt_err}, 32'd0);
          if (exp_st.size() == 0) begin
            chk("status_extra", bus.pkt_done ? 32'd0 : {30'd0, bus.err_code}, 32'hEE);
          end else begin
            e = exp_st.pop_front();
            chk("status", bus.pkt_done ? 32'd0 : {30'd0, bus.err_code}, 32'(e));
            if (e != 0) last_err = 2'(e);
          end
          if (bus.pkt_done) chk("err_code_hold", {30'd0, bus.err_code}, {30'd0, last_err});
        end
      end
      @(posedge clk_main);
      #1;
      if (rd_seen && fifo_q.size() != 0) bus.rf_out = fifo_q.pop_front();
      rd_seen = 1'b0;
      bus.rf_empty = (fifo_q.size() == 0) || (gaps_en && ($urandom % 4 == 0));
      if (hold_ready) bus.pkt_ready = 1'b0;
      else if (rnd_ready) bus.pkt_ready = ($urandom % 3 != 0);
      else bus.pkt_ready = 1'b1;
    end
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_fifo_rd"}, {31'd0, bus.fifo_rd}, 32'd0);
    chk({tag, "_data"}, {24'd0, bus.pkt_data}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.pkt_valid}, 32'd0);
    chk({tag, "_last"}, {31'd0, bus.pkt_last}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.pkt_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, bus.pkt_err}, 32'd0);
    chk({tag, "_code"}, {30'd0, bus.err_code}, 32'd0);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk_main);
    @(negedge clk_main);
    chk_outputs_zero("reset");
    @(posedge clk_main);
    #1 rst_main = 1'b0;
    mon_en = 1'b1;

    // Good frame, bad checksum, junk lead-in, bad lengths, timeout
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}; send(); drain();
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68}; send(); drain();
    stim = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}; send(); drain();
    stim = '{8'hA5, 8'h00, 8'hA5, 8'h21, 8'hA5, 8'h01, 8'h7E, 8'h7F}; send(); drain();
    stim = '{8'hA5, 8'h02, 8'h11}; send(); drain();
    stim = '{8'hA5}; send(); drain();
    stim = '{8'hA5, 8'h20}; for (int k = 0; k < 32; k++) stim.push_back(8'(k)); stim.push_back(8'h10); send(); drain();

    // Back-pressure stall mid-payload
    hold_ready = 1'b1;
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}; send();
    t = 0;
    while (!bus.pkt_valid && t < 100) begin @(negedge clk_main); t++; end
    chk("stall_valid", {31'd0, bus.pkt_valid}, 32'd1);
    repeat (20) begin
      @(negedge clk_main);
      chk("stall_data", {24'd0, bus.pkt_data}, 32'h11);
      chk("stall_rd", {31'd0, bus.fifo_rd}, 32'd0);
      chk("stall_err", {31'd0, bus.pkt_err}, 32'd0);
    end
    hold_ready = 1'b0;
    drain();

    // Randomized streams with FIFO gaps and random back-pressure
    rnd_ready = 1'b1;
    gaps_en = 1'b1;
    for (int r = 0; r < 10; r++) begin
      int items;
      int kind;
      stim.delete();
      items = 1 + $urandom % 4;
      for (int it = 0; it < items; it++) begin
        kind = $urandom % 5;
        if (kind == 0) begin
          for (int j = 0; j < 1 + $urandom % 3; j++) begin
            logic [7:0] jb;
            jb = 8'($urandom);
            if (jb == SYNC) jb = 8'h5A;
            stim.push_back(jb);
          end
        end else if (kind <= 2) add_frame(0);
        else if (kind == 3) add_frame(1);
        else add_frame(2);
      end
      if ($urandom % 3 == 0) begin
        for (int j = 0; j < 1 + $urandom % 3; j++) if (stim.size() > 1) void'(stim.pop_back());
      end
      send();
      drain();
    end
    rnd_ready = 1'b0;
    gaps_en = 1'b0;

    // Reset in the middle of a frame drops it silently
    mon_en = 1'b0;
    hold_ready = 1'b1;
    fifo_q = '{8'hA5, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04};
    t = 0;
    while (!bus.pkt_valid && t < 100) begin @(negedge clk_main); t++; end
    chk("pre_rst_valid", {31'd0, bus.pkt_valid}, 32'd1);
    @(posedge clk_main);
    #1 rst_main = 1'b1;
    @(posedge clk_main);
    @(negedge clk_main);
    chk_outputs_zero("midrst");
    @(posedge clk_main);
    #1 rst_main = 1'b0;
    fifo_q.delete();
    hold_ready = 1'b0;
    last_err = 2'b00;
    mon_en = 1'b1;
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}; send(); drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
